// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register: main + skid entry, synchronous flush,
// registered occupancy and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int PC_BITS   = 32,
    parameter int IR_BITS   = 32,
    parameter int CTRL_BITS = 16,
    parameter int DATA_BITS = 32,
    parameter int NUM_DATA  = 3,
    parameter int CNT_BITS  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PC_BITS-1:0]            in_pc,
    input  logic [IR_BITS-1:0]            in_ir,
    input  logic [CTRL_BITS-1:0]          in_ctrl,
    input  logic [NUM_DATA*DATA_BITS-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PC_BITS-1:0]            out_pc,
    output logic [IR_BITS-1:0]            out_ir,
    output logic [CTRL_BITS-1:0]          out_ctrl,
    output logic [NUM_DATA*DATA_BITS-1:0] out_data,
    output logic [1:0]                    occupancy,
    output logic [CNT_BITS-1:0]           stall_cnt
);

    localparam int DW = NUM_DATA * DATA_BITS;
    localparam int PW = PC_BITS + IR_BITS + CTRL_BITS + DW;

    logic [PW-1:0]       in_payload;
    logic [PW-1:0]       main_q, main_d;
    logic [PW-1:0]       skid_q, skid_d;
    logic                main_valid_q, main_valid_d;
    logic                skid_valid_q, skid_valid_d;
    logic [1:0]          occ_q;
    logic [CNT_BITS-1:0] stall_q;
    logic                accept;
    logic                main_free;
    logic                stalled;

    // Lanes travel as one opaque vector, so bit order is untouched for any NUM_DATA.
    assign in_payload = {in_pc, in_ir, in_ctrl, in_data};

    // Ready depends only on the skid flag, never on out_ready.
    assign in_ready  = ~skid_valid_q;
    assign accept    = in_valid & ~skid_valid_q;
    assign main_free = ~main_valid_q | out_ready;
    assign stalled   = main_valid_q & ~out_ready;

    // NOTE: every signal gets a default first, so no path through this block infers a latch.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (main_free) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                skid_d       = accept ? in_payload : '0;
            end else if (accept) begin
                main_d       = in_payload;
                main_valid_d = 1'b1;
            end else begin
                // Vacated entries are zeroed so the outputs read as a clean bubble.
                main_d       = '0;
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = in_payload;
            skid_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            occ_q        <= 2'd0;
            if (rst) begin
                stall_q <= '0;
            end
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            occ_q        <= {1'b0, main_valid_d} + {1'b0, skid_valid_d};
            if (stalled && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_BITS'(1);
            end
        end
    end

    assign out_valid = main_valid_q;
    assign {out_pc, out_ir, out_ctrl, out_data} = main_q;
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a 4-lane and a 1-lane instance share stimulus and
// are both compared each checkpoint against a 2-deep FIFO queue model.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  ir;
        logic [15:0]  ctrl;
        logic [127:0] data;
    } entry_t;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, out_ready;
    logic [31:0]  in_pc, in_ir;
    logic [15:0]  in_ctrl;
    logic [127:0] in_data;

    logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0]  out_pc_a, out_ir_a, out_pc_b, out_ir_b;
    logic [15:0]  out_ctrl_a, out_ctrl_b;
    logic [127:0] out_data_a;
    logic [31:0]  out_data_b;
    logic [1:0]   occ_a, occ_b;
    logic [3:0]   stall_a, stall_b;

    entry_t q[$];
    int     stall_m;
    int     n_checks = 0;
    int     n_pass   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.NUM_DATA(4), .CNT_BITS(4)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .in_pc(in_pc), .in_ir(in_ir), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_pc(out_pc_a), .out_ir(out_ir_a), .out_ctrl(out_ctrl_a), .out_data(out_data_a),
        .occupancy(occ_a), .stall_cnt(stall_a)
    );

    pipe_stage_reg #(.NUM_DATA(1), .CNT_BITS(4)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_pc(in_pc), .in_ir(in_ir), .in_ctrl(in_ctrl), .in_data(in_data[31:0]),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_pc(out_pc_b), .out_ir(out_ir_b), .out_ctrl(out_ctrl_b), .out_data(out_data_b),
        .occupancy(occ_b), .stall_cnt(stall_b)
    );

    // Everything observable from both instances, in one vector.
    function automatic logic [335:0] observed();
        return {out_valid_a, out_pc_a, out_ir_a, out_ctrl_a, out_data_a,
                out_valid_b, out_pc_b, out_ir_b, out_ctrl_b, out_data_b,
                in_ready_a, occ_a, stall_a, in_ready_b, occ_b, stall_b};
    endfunction

    // Expected view: head of the queue (or an all-zero bubble), room, depth, stall count.
    function automatic logic [335:0] expected();
        logic [208:0] pa;
        logic [112:0] pb;
        logic [6:0]   st;
        pa = '0;
        pb = '0;
        if (q.size() > 0) begin
            pa = {1'b1, q[0]};
            pb = {1'b1, q[0].pc, q[0].ir, q[0].ctrl, q[0].data[31:0]};
        end
        st = {q.size() < 2, 2'(q.size()), 4'(stall_m)};
        return {pa, pb, st, st};
    endfunction

    // One clock: advance the model from the inputs the DUTs see at this edge.
    task automatic tick();
        entry_t e;
        bit     acc;
        e = '{pc: in_pc, ir: in_ir, ctrl: in_ctrl, data: in_data};
        if (rst) begin
            q.delete();
            stall_m = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && !out_ready && stall_m < 15) stall_m++;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_ir    = $urandom;
        in_ctrl  = 16'($urandom);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        offer(32'hdead_beef);
        tick();
        flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (observed() !== expected())
            $display("FAIL reset obs=%h exp=%h", observed(), expected());
        else n_pass++;
    endtask

    task automatic test_pass_through();
        offer(32'h0040_0000);
        in_ir     = 32'h2008_0005;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if ({out_valid_a, out_pc_a, out_ir_a, occ_a, stall_a} !== {1'b1, 32'h0040_0000, 32'h2008_0005, 2'd1, 4'd0})
            $display("FAIL pass_through_fields obs pc=%h ir=%h occ=%0d", out_pc_a, out_ir_a, occ_a);
        else n_pass++;
        n_checks++;
        if (observed() !== expected())
            $display("FAIL pass_through obs=%h exp=%h", observed(), expected());
        else n_pass++;
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (observed() !== expected())
            $display("FAIL pass_through_drain obs=%h exp=%h", observed(), expected());
        else n_pass++;
    endtask

    task automatic test_skid();
        logic [31:0] seen[3];
        out_ready = 1'b0;
        offer(32'h100); tick();
        offer(32'h104); tick();
        offer(32'h108); tick(); tick();
        n_checks++;
        if ({occ_a, in_ready_a, occ_b, in_ready_b} !== {2'd2, 1'b0, 2'd2, 1'b0})
            $display("FAIL skid_full occ=%0d in_ready=%b req occ=2 in_ready=0", occ_a, in_ready_a);
        else n_pass++;
        n_checks++;
        if (observed() !== expected())
            $display("FAIL skid_hold obs=%h exp=%h", observed(), expected());
        else n_pass++;
        out_ready = 1'b1;
        seen[0] = out_pc_a;
        tick();
        seen[1] = out_pc_a;
        tick();
        in_valid = 1'b0;
        seen[2] = out_pc_a;
        n_checks++;
        if ({seen[0], seen[1], seen[2]} !== {32'h100, 32'h104, 32'h108})
            $display("FAIL skid_order got %h %h %h req 100 104 108", seen[0], seen[1], seen[2]);
        else n_pass++;
        tick();
        n_checks++;
        if (observed() !== expected())
            $display("FAIL skid_empty obs=%h exp=%h", observed(), expected());
        else n_pass++;
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        offer(32'h1f0); tick();
        offer(32'h1f4); tick();
        offer(32'h200);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({out_valid_a, out_pc_a, out_ir_a, out_ctrl_a, out_data_a, occ_a, in_ready_a} !==
            {1'b1 == 1'b0, 208'h0, 2'd0, 1'b1})
            $display("FAIL flush_bubble valid=%b pc=%h occ=%0d in_ready=%b", out_valid_a, out_pc_a, occ_a, in_ready_a);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (observed() !== expected() || out_pc_a === 32'h200)
            $display("FAIL flush_drop obs=%h exp=%h", observed(), expected());
        else n_pass++;
    endtask

    task automatic test_stall_saturation();
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0;
        offer(32'h300); tick();
        in_valid = 1'b0;
        repeat (20) tick();
        n_checks++;
        if (stall_a !== 4'd15 || stall_b !== 4'd15)
            $display("FAIL stall_saturate got %0d/%0d req 15", stall_a, stall_b);
        else n_pass++;
        flush = 1'b1; tick(); flush = 1'b0;
        n_checks++;
        if (stall_a !== 4'd15 || observed() !== expected())
            $display("FAIL stall_after_flush got %0d req 15 obs=%h exp=%h", stall_a, observed(), expected());
        else n_pass++;
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++;
        if (stall_a !== 4'd0 || stall_b !== 4'd0)
            $display("FAIL stall_reset got %0d/%0d req 0", stall_a, stall_b);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            offer(32'h1000 + 32'(4 * i));
            tick();
            if (!out_valid_a || out_pc_a !== 32'h1000 + 32'(4 * i) || observed() !== expected()) bad++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (bad != 0)
            $display("FAIL back_to_back bad_cycles=%0d req 0", bad);
        else n_pass++;
        tick();
        n_checks++;
        if (observed() !== expected())
            $display("FAIL back_to_back_tail obs=%h exp=%h", observed(), expected());
        else n_pass++;
    endtask

    task automatic test_random();
        int bad = 0;
        int bubble_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            offer($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            tick();
            if (observed() !== expected()) begin
                bad++;
                if (bad <= 3) $display("FAIL random_cycle_%0d obs=%h exp=%h", i, observed(), expected());
            end
            if (!out_valid_a && {out_pc_a, out_ir_a, out_ctrl_a, out_data_a} !== '0) bubble_bad++;
            if (!out_valid_b && {out_pc_b, out_ir_b, out_ctrl_b, out_data_b} !== '0) bubble_bad++;
        end
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (bad != 0)
            $display("FAIL random_scoreboard bad_cycles=%0d req 0", bad);
        else n_pass++;
        n_checks++;
        if (bubble_bad != 0)
            $display("FAIL random_bubble_nonzero count=%0d req 0", bubble_bad);
        else n_pass++;
    endtask

    initial begin
        stall_m = 0;
        test_reset();
        test_pass_through();
        test_skid();
        test_flush_full();
        test_stall_saturation();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic handshaked pipeline-stage register; the next generation of the fixed-field inter-stage latch.
- Carries PC, IR, a packed control bundle and NUM_DATA data lanes between any two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure does not form a combinational path, plus a synchronous flush.
- Also provides an occupancy output and a saturating stall-cycle counter for performance debug.

Parameters:
PC_BITS, 32, PC field width
IR_BITS, 32, instruction field width
CTRL_BITS, 16, packed control-signal bundle width
DATA_BITS, 32, width of one data lane
NUM_DATA, 3, number of data lanes (at least 1)
CNT_BITS, 16, stall counter width

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous clear of all buffered entries (bubble insert)
in_valid  input  1  upstream holds a valid entry
in_ready  output  1  stage can accept an entry this cycle
in_pc  input  PC_BITS  upstream PC
in_ir  input  IR_BITS  upstream instruction
in_ctrl  input  CTRL_BITS  upstream control bundle
in_data  input  NUM_DATA*DATA_BITS  lanes packed; lane k occupies bits [k*DATA_BITS +: DATA_BITS]
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts the output entry
out_pc  output  PC_BITS  head entry PC
out_ir  output  IR_BITS  head entry instruction
out_ctrl  output  CTRL_BITS  head entry control bundle
out_data  output  NUM_DATA*DATA_BITS  head entry data lanes
occupancy  output  2  number of entries held (0, 1 or 2)
stall_cnt  output  CNT_BITS  cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage:
  - Main register (drives the outputs) and skid register, each with its own valid bit.
  - out_valid = main valid.
  - in_ready = NOT skid valid. This is purely registered state, with no combinational path from out_ready.
- Bubble rule: whenever out_valid=0, out_pc, out_ir, out_ctrl and out_data are all 0. Payload registers are zeroed when vacated, not gated at the output.
- Transfers:
  - Accept occurs when in_valid and in_ready are both 1.
  - Drain occurs when out_valid and out_ready are both 1.
- Per-cycle update, in priority order:
  1. rst: both valids cleared, all payload cleared, stall_cnt=0.
  2. flush: both valids and all payload cleared; any input offered that cycle is dropped, even with in_ready=1. stall_cnt is held.
  3. Otherwise:
     - main empty or draining:
       - skid valid: skid moves to main, and an accept (if any) loads skid.
       - skid empty: an accept loads main, and skid stays empty.
       - no accept and skid empty: main clears to a bubble.
     - main full and not draining: an accept loads skid (possible only when skid is empty); main holds.
- Ordering: strict FIFO; entries are never reordered, duplicated or lost except by flush or rst.
- Latency and throughput:
  - Input to output takes 1 cycle when the stage is empty.
  - Sustains 1 entry/cycle with out_ready held high.
- occupancy = main valid + skid valid, registered; it equals 0 on the cycle after rst or flush.
- stall_cnt:
  - Increments by 1 in each cycle where out_valid=1 and out_ready=0.
  - Saturates at all-ones; no wrap-around.
  - Cleared only by rst.
- Simultaneous events:
  - Accept and drain together with skid empty: main is replaced, occupancy stays 1.
  - flush together with rst: same result as rst.
- Mid-operation reset or flush with 2 entries held: both entries are discarded, and in_ready=1 on the next cycle.
- Lane packing must not alter bit order; NUM_DATA=1 must elaborate and behave identically to other values.

Test Plan:
- Reset then pass-through:
  - Stimulus: rst high 2 cycles; then in_valid=1, in_pc=0x00400000, in_ir=0x20080005, out_ready=1.
  - Required: next cycle out_valid=1 with the same fields; occupancy=1; stall_cnt=0.
- Back-pressure and skid:
  - Stimulus: out_ready=0; offer entries A (pc 0x100) then B (pc 0x104).
  - Required: occupancy reaches 2, in_ready=0, and C (pc 0x108) is held upstream.
  - Then raise out_ready: outputs A, B, C in consecutive cycles.
- Flush with full buffer:
  - Stimulus: 2 entries held; flush=1 while in_valid=1 offers pc 0x200.
  - Required: next cycle out_valid=0, all out fields 0, occupancy=0, in_ready=1; pc 0x200 never appears.
- Stall counter saturation:
  - Stimulus: CNT_BITS=4; hold out_valid=1, out_ready=0 for 20 cycles.
  - Required: stall_cnt=15 and holding; a later flush leaves it at 15; rst returns it to 0.
- Full-rate streaming:
  - Stimulus: 64 back-to-back entries with incrementing pc, out_ready=1.
  - Required: output in order, one per cycle, with no bubbles after the first cycle.
- Randomised back-pressure:
  - Stimulus: random in_valid/out_ready over 1000 cycles with NUM_DATA=1 and NUM_DATA=4.
  - Required: scoreboard shows an in-order, lossless stream, and all out fields are 0 whenever out_valid=0.
